// File: rtl/db9_pkg.sv
// Shared types and constants for the DB9 / Mega Drive pad scanner.
// Word layout, pin order and state/pad-type encodings used by RTL and bench.
package db9_pkg;

    localparam int unsigned PIN_W  = 6;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned SH_W   = 12;

    // Button word bit positions (active-high)
    localparam int unsigned JB_R     = 0;
    localparam int unsigned JB_L     = 1;
    localparam int unsigned JB_D     = 2;
    localparam int unsigned JB_U     = 3;
    localparam int unsigned JB_B     = 4;
    localparam int unsigned JB_C     = 5;
    localparam int unsigned JB_A     = 6;
    localparam int unsigned JB_START = 7;
    localparam int unsigned JB_MODE  = 8;
    localparam int unsigned JB_X     = 9;
    localparam int unsigned JB_Y     = 10;
    localparam int unsigned JB_Z     = 11;

    // Input pin positions on joy_in (active-low on the wire)
    localparam int unsigned PIN_U = 0;
    localparam int unsigned PIN_D = 1;
    localparam int unsigned PIN_L = 2;
    localparam int unsigned PIN_R = 3;
    localparam int unsigned PIN_6 = 4;
    localparam int unsigned PIN_9 = 5;

    typedef enum logic [1:0] {
        PAD_NONE = 2'd0,
        PAD_MD3  = 2'd1,
        PAD_MD6  = 2'd2
    } pad_type_t;

    typedef enum logic {
        SCAN = 1'b0,
        IDLE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/db9md_pad_scanner_if.sv
// Pad-side bus: shared input pins, select/split drive and the decoded words.
interface db9md_pad_scanner_if;
    import db9_pkg::*;

    logic [PIN_W-1:0]  joy_in;
    logic              joy_mdsel;
    logic              joy_split;
    logic [WORD_W-1:0] joystick1;
    logic [WORD_W-1:0] joystick2;
    pad_type_t         pad_type1;
    pad_type_t         pad_type2;
    logic              joy_strobe;

    modport master (
        input  joy_in,
        output joy_mdsel, joy_split, joystick1, joystick2,
               pad_type1, pad_type2, joy_strobe
    );

    modport slave (
        output joy_in,
        input  joy_mdsel, joy_split, joystick1, joystick2,
               pad_type1, pad_type2, joy_strobe
    );

endinterface

// File: rtl/db9_sync.sv
// Two-flop synchronizer for the asynchronous DB9 input pins.
module db9_sync
    import db9_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PIN_W-1:0] d,
    output logic [PIN_W-1:0] q
);

    logic [PIN_W-1:0] meta_q;

    // Pins idle high, so reset to the released level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '1;
            q      <= '1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/db9md_pad_scanner.sv
// Scans two DB9 ports through one shared pin bus, decoding Atari sticks and
// Mega Drive 3/6-button pads into committed active-high button words.
module db9md_pad_scanner
    import db9_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 400,
    parameter int unsigned IDLE_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    db9md_pad_scanner_if.master  pad
);

    localparam int unsigned CNT_MAX = (STEP_CYCLES > IDLE_CYCLES) ? STEP_CYCLES : IDLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STEP_RELOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_RELOAD = CNT_W'(IDLE_CYCLES - 1);

    logic [PIN_W-1:0] joy_s;
    logic [PIN_W-1:0] act;

    scan_state_t       state_q, state_d;
    logic [2:0]        phase_q, phase_d, phase_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              split_q, split_d;
    logic              mdsel_q, mdsel_d;
    logic [SH_W-1:0]   sh_word_q, sh_word_d;
    logic              sh_md_q, sh_md_d;
    logic              sh_six_q, sh_six_d;
    logic [WORD_W-1:0] joy1_q, joy1_d, joy2_q, joy2_d;
    pad_type_t         type1_q, type1_d, type2_q, type2_d;
    pad_type_t         commit_type;
    logic              strobe_q, strobe_d;

    db9_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pad.joy_in),
        .q       (joy_s)
    );

    assign act = ~joy_s;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SCAN;
            phase_q   <= 3'd0;
            cnt_q     <= STEP_RELOAD;
            split_q   <= 1'b0;
            mdsel_q   <= 1'b1;
            sh_word_q <= '0;
            sh_md_q   <= 1'b0;
            sh_six_q  <= 1'b0;
            joy1_q    <= '0;
            joy2_q    <= '0;
            type1_q   <= PAD_NONE;
            type2_q   <= PAD_NONE;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            split_q   <= split_d;
            mdsel_q   <= mdsel_d;
            sh_word_q <= sh_word_d;
            sh_md_q   <= sh_md_d;
            sh_six_q  <= sh_six_d;
            joy1_q    <= joy1_d;
            joy2_q    <= joy2_d;
            type1_q   <= type1_d;
            type2_q   <= type2_d;
            strobe_q  <= strobe_d;
        end
    end

    // Next-state: phase sequencing, per-phase capture on the last clock, commit
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        split_d   = split_q;
        mdsel_d   = mdsel_q;
        sh_word_d = sh_word_q;
        sh_md_d   = sh_md_q;
        sh_six_d  = sh_six_q;
        joy1_d    = joy1_q;
        joy2_d    = joy2_q;
        type1_d   = type1_q;
        type2_d   = type2_q;
        strobe_d  = 1'b0;
        phase_nx  = phase_q + 3'd1;
        commit_type = sh_md_q ? (sh_six_q ? PAD_MD6 : PAD_MD3) : PAD_NONE;

        case (state_q)
            SCAN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    case (phase_q)
                        3'd0: begin
                            sh_word_d       = '0;
                            sh_md_d         = 1'b0;
                            sh_six_d        = 1'b0;
                            sh_word_d[JB_U] = act[PIN_U];
                            sh_word_d[JB_D] = act[PIN_D];
                            sh_word_d[JB_L] = act[PIN_L];
                            sh_word_d[JB_R] = act[PIN_R];
                            sh_word_d[JB_B] = act[PIN_6];
                            sh_word_d[JB_C] = act[PIN_9];
                        end
                        3'd1: begin
                            sh_md_d = act[PIN_L] & act[PIN_R];
                            if (act[PIN_L] & act[PIN_R]) begin
                                sh_word_d[JB_A]     = act[PIN_6];
                                sh_word_d[JB_START] = act[PIN_9];
                            end else begin
                                // Single-fire stick: its button reports as A
                                sh_word_d[JB_A] = sh_word_q[JB_B];
                                sh_word_d[JB_B] = 1'b0;
                                sh_word_d[JB_C] = 1'b0;
                            end
                        end
                        3'd5: sh_six_d = sh_md_q & (&act[PIN_R:PIN_U]);
                        3'd6: begin
                            if (sh_six_q) begin
                                sh_word_d[JB_Z]    = act[PIN_U];
                                sh_word_d[JB_Y]    = act[PIN_D];
                                sh_word_d[JB_X]    = act[PIN_L];
                                sh_word_d[JB_MODE] = act[PIN_R];
                            end
                        end
                        default: ;
                    endcase

                    if (phase_q == 3'd7) begin
                        if (split_q) begin
                            joy2_d  = WORD_W'(sh_word_q);
                            type2_d = commit_type;
                        end else begin
                            joy1_d  = WORD_W'(sh_word_q);
                            type1_d = commit_type;
                        end
                        strobe_d = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = IDLE_RELOAD;
                        split_d  = ~split_q;
                        mdsel_d  = 1'b1;
                    end else begin
                        phase_d = phase_nx;
                        cnt_d   = STEP_RELOAD;
                        mdsel_d = ~phase_nx[0];
                    end
                end
            end
            IDLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = SCAN;
                    phase_d = 3'd0;
                    cnt_d   = STEP_RELOAD;
                    mdsel_d = 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign pad.joy_mdsel  = mdsel_q;
    assign pad.joy_split  = split_q;
    assign pad.joystick1  = joy1_q;
    assign pad.joystick2  = joy2_q;
    assign pad.pad_type1  = type1_q;
    assign pad.pad_type2  = type2_q;
    assign pad.joy_strobe = strobe_q;

endmodule

// File: tb/tb_db9md_pad_scanner.sv
// Bench for db9md_pad_scanner: behavioural pad models on both ports and a
// schedule/word model checked against the DUT every cycle.
module tb_db9md_pad_scanner;
    import db9_pkg::*;

    localparam int S  = 8;
    localparam int I  = 64;
    localparam int P  = 8 * S + I;
    localparam int T6 = 32;

    localparam int DEV_NONE  = 0;
    localparam int DEV_ATARI = 1;
    localparam int DEV_MD3   = 2;
    localparam int DEV_MD6   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    db9md_pad_scanner_if pad_if ();

    db9md_pad_scanner #(.STEP_CYCLES(S), .IDLE_CYCLES(I)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .pad     (pad_if)
    );

    int          dev[2]      = '{DEV_NONE, DEV_NONE};
    logic [11:0] btn[2]      = '{12'h0, 12'h0};
    int          cnt6[2]     = '{0, 0};
    int          hi_time[2]  = '{0, 0};
    int          last_dev[2] = '{DEV_NONE, DEV_NONE};
    logic        prev_sel[2] = '{1'b1, 1'b1};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    logic [15:0] exp_j[2];
    logic [1:0]  exp_t[2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Pin levels a device presents for a given select level and pulse count
    function automatic logic [5:0] pad_pins(input int d, input logic [11:0] b, input logic sel, input int c);
        logic [5:0] pressed;
        pressed = '0;
        case (d)
            DEV_ATARI: pressed = {1'b0, b[JB_A], b[JB_R], b[JB_L], b[JB_D], b[JB_U]};
            DEV_MD3, DEV_MD6: begin
                if (d == DEV_MD6 && c == 3)
                    pressed = sel ? {b[JB_C], b[JB_B], b[JB_MODE], b[JB_X], b[JB_Y], b[JB_Z]}
                                  : {b[JB_START], b[JB_A], 4'b1111};
                else
                    pressed = sel ? {b[JB_C], b[JB_B], b[JB_R], b[JB_L], b[JB_D], b[JB_U]}
                                  : {b[JB_START], b[JB_A], 2'b11, b[JB_D], b[JB_U]};
            end
            default: pressed = '0;
        endcase
        return ~pressed;
    endfunction

    // Word a device must produce, straight from the button set it holds
    function automatic logic [15:0] model_word(input int d, input logic [11:0] b);
        logic [15:0] w;
        w = '0;
        case (d)
            DEV_ATARI: begin
                w[3:0]  = b[3:0];
                w[JB_A] = b[JB_A];
            end
            DEV_MD3: w[7:0]  = b[7:0];
            DEV_MD6: w[11:0] = b;
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [1:0] model_type(input int d);
        return (d == DEV_MD3) ? 2'd1 : (d == DEV_MD6) ? 2'd2 : 2'd0;
    endfunction

    always_comb begin
        if (pad_if.joy_split)
            pad_if.joy_in = pad_pins(dev[1], btn[1], pad_if.joy_mdsel, cnt6[1]);
        else
            pad_if.joy_in = pad_pins(dev[0], btn[0], pad_if.joy_mdsel, cnt6[0]);
    end

    // 6-button pad pulse counters with high-time timeout
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            logic s;
            s = (int'(pad_if.joy_split) == p) ? pad_if.joy_mdsel : 1'b1;
            if (dev[p] != last_dev[p])        cnt6[p] <= 0;
            else if (prev_sel[p] && !s)       cnt6[p] <= cnt6[p] + 1;
            else if (hi_time[p] >= T6)        cnt6[p] <= 0;
            hi_time[p]  <= s ? hi_time[p] + 1 : 0;
            prev_sel[p] <= s;
            last_dev[p] <= dev[p];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Per-cycle comparison against the schedule and word model
    always @(negedge clk) begin
        int   pos, n, port;
        logic e_sel, e_strobe, e_split;
        if (!rst_n) begin
            exp_j[0] = '0; exp_j[1] = '0;
            exp_t[0] = '0; exp_t[1] = '0;
            check("rst_mdsel",  32'(pad_if.joy_mdsel),  32'd1);
            check("rst_split",  32'(pad_if.joy_split),  32'd0);
            check("rst_strobe", 32'(pad_if.joy_strobe), 32'd0);
            check("rst_joy1",   32'(pad_if.joystick1),  32'd0);
            check("rst_joy2",   32'(pad_if.joystick2),  32'd0);
        end else begin
            pos      = cyc % P;
            n        = cyc / P;
            e_sel    = (pos < 8 * S) ? (((pos / S) % 2) == 0) : 1'b1;
            e_strobe = (pos == 8 * S);
            e_split  = (pos >= 8 * S) ? ((n % 2) == 0) : ((n % 2) == 1);
            if (e_strobe) begin
                port = n % 2;
                exp_j[port] = model_word(dev[port], btn[port]);
                exp_t[port] = model_type(dev[port]);
            end
            check("mdsel",  32'(pad_if.joy_mdsel),  32'(e_sel));
            check("split",  32'(pad_if.joy_split),  32'(e_split));
            check("strobe", 32'(pad_if.joy_strobe), 32'(e_strobe));
            check("joy1",   32'(pad_if.joystick1),  32'(exp_j[0]));
            check("joy2",   32'(pad_if.joystick2),  32'(exp_j[1]));
            check("type1",  32'(pad_if.pad_type1),  32'(exp_t[0]));
            check("type2",  32'(pad_if.pad_type2),  32'(exp_t[1]));
        end
    end

    // Wait for the commit of a port (-1 = any), bounded
    task automatic wait_commit(input int port, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * P + 16 && !seen; i++) begin
            @(negedge clk);
            if (pad_if.joy_strobe && (port < 0 || int'(pad_if.joy_split) == 1 - port))
                seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic set_dev(input int p, input int d, input logic [11:0] b);
        dev[p] = d;
        btn[p] = b;
    endtask

    initial begin
        logic [11:0] b;
        logic        hit;
        int          d, p;

        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        // Empty ports
        wait_commit(0, "commit_empty");
        check("empty_joy1",  32'(pad_if.joystick1), 32'h0);
        check("empty_type1", 32'(pad_if.pad_type1), 32'd0);
        check("empty_split", 32'(pad_if.joy_split), 32'd1);
        check("first_strobe_cyc", 32'(cyc), 32'(8 * S));

        // Atari stick: Up + fire
        repeat (2) @(negedge clk);
        b = '0; b[JB_U] = 1'b1; b[JB_A] = 1'b1;
        set_dev(0, DEV_ATARI, b);
        wait_commit(0, "commit_atari");
        check("atari_joy1",  32'(pad_if.joystick1), 32'h0048);
        check("atari_type1", 32'(pad_if.pad_type1), 32'd0);

        // 3-button: A + Start + Right
        repeat (2) @(negedge clk);
        b = '0; b[JB_A] = 1'b1; b[JB_START] = 1'b1; b[JB_R] = 1'b1;
        set_dev(0, DEV_MD3, b);
        wait_commit(0, "commit_md3");
        check("md3_joy1",  32'(pad_if.joystick1), 32'h00C1);
        check("md3_type1", 32'(pad_if.pad_type1), 32'd1);

        // 6-button on port 2: Z + X
        repeat (2) @(negedge clk);
        b = '0; b[JB_Z] = 1'b1; b[JB_X] = 1'b1;
        set_dev(1, DEV_MD6, b);
        wait_commit(1, "commit_md6");
        check("md6_joy2",  32'(pad_if.joystick2), 32'h0A00);
        check("md6_type2", 32'(pad_if.pad_type2), 32'd2);
        check("md6_joy1",  32'(pad_if.joystick1), 32'h00C1);

        // Reset during phase 4 of a port-1 scan
        repeat (2) @(negedge clk);
        b = '0; b[JB_U] = 1'b1; b[JB_B] = 1'b1; b[JB_C] = 1'b1;
        set_dev(0, DEV_MD3, b);
        hit = 1'b0;
        for (int i = 0; i < 2 * P + 16 && !hit; i++) begin
            @(negedge clk);
            if (!pad_if.joy_split && (cyc % P) >= 4 * S && (cyc % P) < 5 * S) hit = 1'b1;
        end
        check("reach_phase4", 32'(hit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_joy1",  32'(pad_if.joystick1),  32'h0);
        check("midrst_joy2",  32'(pad_if.joystick2),  32'h0);
        check("midrst_type2", 32'(pad_if.pad_type2),  32'd0);
        check("midrst_mdsel", 32'(pad_if.joy_mdsel),  32'd1);
        check("midrst_split", 32'(pad_if.joy_split),  32'd0);
        repeat (40) @(negedge clk);
        rst_n = 1'b1;
        wait_commit(0, "commit_after_rst");
        check("post_rst_joy1",  32'(pad_if.joystick1), 32'h0038);
        check("post_rst_type1", 32'(pad_if.pad_type1), 32'd1);
        check("post_rst_joy2",  32'(pad_if.joystick2), 32'h0);
        check("post_rst_cyc",   32'(cyc), 32'(8 * S));

        // Randomized hot-plug and button changes between scans
        for (int it = 0; it < 16; it++) begin
            repeat (2) @(negedge clk);
            p = int'($urandom_range(1, 0));
            d = int'($urandom_range(3, 0));
            b = 12'($urandom);
            if (d == DEV_ATARI && b[JB_L] && b[JB_R]) b[JB_R] = 1'b0;
            if (d == DEV_MD3 && b[JB_U] && b[JB_D])   b[JB_D] = 1'b0;
            set_dev(p, d, b);
            wait_commit(-1, "commit_rand");
        end
        wait_commit(-1, "commit_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
